// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  // Default data width of every data port
  localparam int FIFO_WIDTH_DEF = 16;

  // Default width of the per-requester accepted-write counters
  localparam int CNT_WIDTH_DEF = 8;

  // Arbiter phases: wait for a request, drive the write, observe the FIFO reply
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_sel.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the prio side.
module fifo_rr_sel (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic winner,
  output logic valid
);

  // Tie resolved by prio; otherwise whichever side is requesting (req1 alone -> 1)
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? prio : req1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates two write requesters onto one FIFO write port. Each write takes
// three cycles (IDLE/ISSUE/ACK); grants alternate when both sides contend.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [FIFO_WIDTH-1:0] data0,
  input  logic [FIFO_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  nack0,
  output logic                  nack1,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1,
  output logic                  err,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_overflow
);

  arb_state_t           state;
  logic                 owner;
  logic                 prio;
  logic                 winner;
  logic                 valid;
  logic                 in_issue;
  logic                 in_ack;
  logic [CNT_WIDTH-1:0] cnt [2];

  fifo_rr_sel u_sel (
    .req0   (req0),
    .req1   (req1),
    .prio   (prio),
    .winner (winner),
    .valid  (valid)
  );

  // Arbitration FSM; fifo_full is only looked at while idle, so a write in
  // flight always completes and the FIFO itself reports any overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      prio         <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && !fifo_full) begin
            state        <= ISSUE;
            owner        <= winner;
            prio         <= ~winner;
            fifo_data_in <= winner ? data1 : data0;
          end
        end
        ISSUE:   state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-requester acknowledged-write counters, bumped as ACK closes; wrap freely
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt[gi] <= '0;
        end else if (in_ack && fifo_wr_ack && (owner == 1'(gi))) begin
          cnt[gi] <= cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Sticky overflow flag, captured as ACK closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (in_ack && fifo_overflow) begin
      err <= 1'b1;
    end
  end

  // Strobes decoded from the registered state only; reset forces IDLE so they drop at once
  always_comb begin
    in_issue   = (state == ISSUE);
    in_ack     = (state == ACK);
    fifo_wr_en = in_issue;
    gnt0       = in_issue & ~owner;
    gnt1       = in_issue &  owner;
    done0      = in_ack & ~owner &  fifo_wr_ack;
    done1      = in_ack &  owner &  fifo_wr_ack;
    nack0      = in_ack & ~owner & ~fifo_wr_ack;
    nack1      = in_ack &  owner & ~fifo_wr_ack;
    cnt0       = cnt[0];
    cnt1       = cnt[1];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a timestamp-based
// transaction model: a grant taken at edge g drives the write for the cycle
// after g, the reply is seen the cycle after that, and results land at g+2.
module tb_fifo_wr_arbiter;

  localparam int FW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [FW-1:0] data0 = '0, data1 = '0;
  logic          fifo_full = 1'b0, fifo_wr_ack = 1'b0, fifo_overflow = 1'b0;
  logic          gnt0, gnt1, done0, done1, nack0, nack1, err, fifo_wr_en;
  logic [CW-1:0] cnt0, cnt1;
  logic [FW-1:0] fifo_data_in;

  fifo_wr_arbiter #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .req1          (req1),
    .data0         (data0),
    .data1         (data1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .done0         (done0),
    .done1         (done1),
    .nack0         (nack0),
    .nack1         (nack1),
    .cnt0          (cnt0),
    .cnt1          (cnt1),
    .err           (err),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: edge index of the last grant and the results it owes
  int            edge_no = 0;
  int            g_edge  = -100;
  int            m_owner = 0;
  int            m_prio  = 0;
  int            m_cnt [2];
  int            m_err   = 0;
  logic [FW-1:0] m_data  = '0;
  int            order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g_edge   = -100;
    m_owner  = 0;
    m_prio   = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_err    = 0;
    m_data   = '0;
  endtask

  // Applied at each posedge with the inputs that were held across it
  task automatic model_edge();
    edge_no++;
    if (rst) begin
      model_reset();
    end else begin
      if (edge_no == g_edge + 2) begin
        if (fifo_wr_ack)   m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CW);
        if (fifo_overflow) m_err = 1;
      end
      if (edge_no >= g_edge + 3 && (req0 || req1) && !fifo_full) begin
        m_owner = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
        m_prio  = 1 - m_owner;
        g_edge  = edge_no;
        m_data  = (m_owner == 1) ? data1 : data0;
      end
    end
  endtask

  task automatic check_outputs();
    logic iss, ak, o0, o1;
    iss = (edge_no == g_edge);
    ak  = (edge_no == g_edge + 1);
    o0  = (m_owner == 0);
    o1  = (m_owner == 1);
    if (iss) $display("txn edge=%0d owner=%0d data=%h", edge_no, m_owner, m_data);
    chk("wr_en", fifo_wr_en, iss);
    chk("gnt0",  gnt0,  iss & o0);
    chk("gnt1",  gnt1,  iss & o1);
    chk("done0", done0, ak & o0 & fifo_wr_ack);
    chk("done1", done1, ak & o1 & fifo_wr_ack);
    chk("nack0", nack0, ak & o0 & ~fifo_wr_ack);
    chk("nack1", nack1, ak & o1 & ~fifo_wr_ack);
    chk("cnt0",  cnt0,  m_cnt[0]);
    chk("cnt1",  cnt1,  m_cnt[1]);
    chk("err",   err,   m_err);
    chk("data",  fifo_data_in, m_data);
  endtask

  // One clock cycle: check mid-cycle, advance model on posedge, return at negedge
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    fifo_full = 1'b0; fifo_wr_ack = 1'b0; fifo_overflow = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    #1;
    do_reset();

    // Single requester, acked write
    req0 = 1'b1; data0 = 16'hA5A5; fifo_wr_ack = 1'b1;
    tick();
    chk("t035_gnt0", gnt0, 1);
    chk("t035_wr_en", fifo_wr_en, 1);
    chk("t035_data", fifo_data_in, 16'hA5A5);
    req0 = 1'b0;
    tick();
    chk("t035_done0", done0, 1);
    tick();
    chk("t035_cnt0", cnt0, 1);

    // Both held: alternating grants from reset priority
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h1111; data1 = 16'h2222; fifo_wr_ack = 1'b1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      tick();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    chk("t036_ngrants", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("t036_order", order[i], i % 2);
    tick();
    tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("t036_cnt0", cnt0, 2);
    chk("t036_cnt1", cnt1, 2);

    // FIFO full blocks the grant until it clears
    do_reset();
    fifo_full = 1'b1; req1 = 1'b1; data1 = 16'hBEEF; fifo_wr_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t037_no_gnt1", gnt1, 0);
      chk("t037_no_wr_en", fifo_wr_en, 0);
    end
    fifo_full = 1'b0;
    tick();
    chk("t037_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    tick();

    // Unacknowledged write with overflow
    req0 = 1'b1; data0 = 16'h0F0F; fifo_wr_ack = 1'b0; fifo_overflow = 1'b1;
    tick();
    chk("t038_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick();
    chk("t038_nack0", nack0, 1);
    chk("t038_done0", done0, 0);
    tick();
    chk("t038_err", err, 1);
    chk("t038_cnt0", cnt0, 0);
    fifo_overflow = 1'b0;
    tick();
    tick();
    chk("t038_err_sticky", err, 1);

    // Reset in the middle of ISSUE
    req0 = 1'b1; data0 = 16'h5A5A; fifo_wr_ack = 1'b1;
    tick();
    chk("t039_gnt0", gnt0, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t039_wr_en", fifo_wr_en, 0);
    chk("t039_gnt0_drop", gnt0, 0);
    chk("t039_err", err, 0);
    chk("t039_cnt1", cnt1, 0);
    tick();
    rst = 1'b0; req0 = 1'b0;
    tick();
    chk("t039_no_done", done0, 0);
    chk("t039_no_nack", nack0, 0);
    tick();

    // Counter wrap after 256 acked writes
    do_reset();
    req0 = 1'b1; data0 = 16'h0001; fifo_wr_ack = 1'b1;
    repeat (767) tick();
    chk("t040_cnt0_255", cnt0, 255);
    tick();
    chk("t040_cnt0_wrap", cnt0, 0);
    req0 = 1'b0;
    tick();
    tick();

    // Randomized traffic with well-behaved requesters (plus occasional early drops)
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (req0) begin
        if ((edge_no == g_edge && m_owner == 0) || $urandom_range(15) == 0) req0 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        req0 = 1'b1; data0 = 16'($urandom);
      end
      if (req1) begin
        if ((edge_no == g_edge && m_owner == 1) || $urandom_range(15) == 0) req1 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        req1 = 1'b1; data1 = 16'($urandom);
      end
      fifo_full     = ($urandom_range(3) == 0);
      fifo_wr_ack   = ($urandom_range(3) != 0);
      fifo_overflow = ($urandom_range(7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data width of every data port.
REQ-002 Parameter CNT_WIDTH, default 8, width of per-requester accepted-write counters.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  requester write request, held until gnt.
REQ-006 data0 / data1  input  FIFO_WIDTH  requester write data, stable while req high.
REQ-007 gnt0 / gnt1  output  1  one-cycle grant pulse.
REQ-008 done0 / done1  output  1  one-cycle pulse: granted write acknowledged by FIFO.
REQ-009 nack0 / nack1  output  1  one-cycle pulse: granted write not acknowledged.
REQ-010 cnt0 / cnt1  output  CNT_WIDTH  count of acknowledged writes per requester.
REQ-011 err  output  1  sticky; FIFO overflow seen.
REQ-012 fifo_wr_en  output  1  FIFO write enable.
REQ-013 fifo_data_in  output  FIFO_WIDTH  FIFO write data.
REQ-014 fifo_full, fifo_wr_ack, fifo_overflow  input  1 each  FIFO status flags.

Function
REQ-015 FSM states IDLE, ISSUE, ACK; one write per 3 cycles maximum.
REQ-016 IDLE -> ISSUE when (req0|req1) & !fifo_full at posedge; otherwise stay IDLE.
REQ-017 ISSUE -> ACK unconditionally; ACK -> IDLE unconditionally.
REQ-018 Owner chosen in IDLE: single requester wins; both requesting -> requester equal to prio bit wins.
REQ-019 prio set to the non-winning requester on each grant (round-robin).
REQ-020 On IDLE->ISSUE transition, winner's data registered into fifo_data_in and owner registered.
REQ-021 fifo_wr_en = 1 exactly in ISSUE; gnt_owner = 1 exactly in ISSUE; other gnt 0.
REQ-022 In ACK: done_owner = fifo_wr_ack; nack_owner = !fifo_wr_ack (combinational from state, owner, flag).
REQ-023 cnt_owner increments at end of ACK when fifo_wr_ack = 1; wraps 2^CNT_WIDTH-1 -> 0.
REQ-024 err set at end of ACK when fifo_overflow = 1; cleared only by rst.
REQ-025 fifo_full sampled only in IDLE; full during ISSUE/ACK does not abort the write (FIFO reports overflow).
REQ-026 Requester dropping req before gnt: no grant, no state change.
REQ-027 fifo_data_in holds last granted value outside ISSUE.

Reset
REQ-028 rst asserted: state=IDLE, prio=0, owner=0, fifo_data_in=0, cnt0=cnt1=0, err=0 immediately, without waiting for a clock edge.
REQ-029 All pulse outputs and fifo_wr_en = 0 while rst high.
REQ-030 Reset mid-ISSUE/ACK abandons the write; no done/nack generated.
REQ-031 First IDLE evaluation occurs at the first posedge after rst deasserts.

Structure
REQ-032 FIFO_WIDTH default, arb state enum type (IDLE/ISSUE/ACK) in shared package fifo_arb_pkg.
REQ-033 Round-robin select isolated in sub-module fifo_rr_sel (inputs req0, req1, prio; output winner, valid), purely combinational.
REQ-034 Outputs gnt/done/nack/wr_en decoded from registered state only (plus fifo_wr_ack for done/nack).

Verification
REQ-035 req0 only, data0=16'hA5A5, FIFO acks -> gnt0 cycle 2, fifo_data_in=A5A5 with wr_en, done0 cycle 3, cnt0=1.
REQ-036 req0 & req1 held, 4 writes, acks always -> grant order 0,1,0,1; cnt0=cnt1=2.
REQ-037 fifo_full=1 with req1 held 5 cycles -> no gnt1, wr_en stays 0; full drops -> gnt1 next cycle.
REQ-038 Grant then fifo_wr_ack=0, fifo_overflow=1 in ACK -> nack0 pulse, err=1 sticky, cnt0 unchanged.
REQ-039 rst asserted during ISSUE -> wr_en, gnt drop same cycle; no done/nack; cnt, err = 0.
REQ-040 256 acked writes from req0 with CNT_WIDTH=8 -> cnt0 wraps to 0.
